// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and parameter-legality predicates for the sync_fifo family.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;

  function automatic int fifo_addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Pointers and count both need one bit beyond the address to reach DEPTH.
  function automatic int fifo_ptr_w(input int depth);
    return fifo_addr_w(depth) + 1;
  endfunction

  function automatic int fifo_cnt_w(input int depth);
    return fifo_addr_w(depth) + 1;
  endfunction

  function automatic bit fifo_depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit fifo_afull_ok(input int depth, input int th);
    return (th >= 1) && (th <= depth);
  endfunction

  function automatic bit fifo_aempty_ok(input int depth, input int th);
    return (th >= 0) && (th <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port FIFO storage; registered read by default, asynchronous
// read when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  localparam int ADDR_W    = fifo_addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [ADDR_W-1:0]     w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_en,
  input  logic [ADDR_W-1:0]     r_addr,
  output logic [DATA_WIDTH-1:0] r_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic unused_ctrl;
  assign unused_ctrl = ^{rst_n, r_en};
  assign r_data      = mem[r_addr];
`else
  // Output register holds the last popped word between reads.
  always_ff @(posedge clk) begin
    if (!rst_n)    r_data <= '0;
    else if (r_en) r_data <= mem[r_addr];
  end
`endif

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, threshold flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 2,
  localparam int ADDR_W    = fifo_addr_w(DEPTH),
  localparam int PTR_W     = fifo_ptr_w(DEPTH),
  localparam int CNT_W     = fifo_cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);

  if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two and >= 2");
  end
  if (!fifo_afull_ok(DEPTH, AFULL_TH)) begin : g_bad_afull
    $error("sync_fifo_flags: AFULL_TH must be in 1..DEPTH");
  end
  if (!fifo_aempty_ok(DEPTH, AEMPTY_TH)) begin : g_bad_aempty
    $error("sync_fifo_flags: AEMPTY_TH must be in 0..DEPTH-1");
  end

  logic [PTR_W-1:0] w_ptr, r_ptr;
  logic             wr_ok, rd_ok;

  assign wr_ok = w_en & ~full;
  assign rd_ok = r_en & ~empty;

  // Flags decode from the registered count only, so they never glitch.
  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(AFULL_TH));
  assign almost_empty = (count <= CNT_W'(AEMPTY_TH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) w_ptr <= w_ptr + 1'b1;
      if (rd_ok) r_ptr <= r_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow  <= w_en & full;
      underflow <= r_en & empty;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_valid = ~empty;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) rd_valid <= 1'b0;
    else        rd_valid <= rd_ok;
  end
`endif

  // Write strobe is masked during reset so reset wins over a same-cycle write.
  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .w_en   (wr_ok & rst_n),
    .w_addr (w_ptr[ADDR_W-1:0]),
    .w_data (data_in),
    .r_en   (rd_ok),
    .r_addr (r_ptr[ADDR_W-1:0]),
    .r_data (data_out)
  );

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomised and directed bench for sync_fifo_flags against a queue-based model.
// Honours SYNC_FIFO_FWFT_EN when defined.
module tb_sync_fifo_flags;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF_TH = DEPTH - 2;
  localparam int AE_TH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          r_en = 1'b0;
  logic [DW-1:0] data_out;
  logic          rd_valid, full, empty, almost_full, almost_empty;
  logic [CW-1:0] count;
  logic          overflow, underflow;

  sync_fifo_flags #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AFULL_TH   (AF_TH),
    .AEMPTY_TH  (AE_TH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .w_en         (w_en),
    .data_in      (data_in),
    .r_en         (r_en),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: the FIFO is just a queue; outputs follow from its size.
  logic [DW-1:0] q[$];
  logic          m_ov, m_un, m_rv;
  logic [DW-1:0] m_do;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ov = 1'b0; m_un = 1'b0; m_rv = 1'b0; m_do = '0;
    end else begin
      automatic bit wa = w_en && (q.size() < DEPTH);
      automatic bit ra = r_en && (q.size() > 0);
      m_ov = w_en && (q.size() == DEPTH);
      m_un = r_en && (q.size() == 0);
      m_rv = ra;
      if (ra) begin
        m_do = q[0];
        void'(q.pop_front());
      end
      if (wa) q.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      automatic int n = q.size();
      chk("count", 32'(count), 32'(n));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("almost_full", 32'(almost_full), 32'(n >= AF_TH));
      chk("almost_empty", 32'(almost_empty), 32'(n <= AE_TH));
      chk("overflow", 32'(overflow), 32'(m_ov));
      chk("underflow", 32'(underflow), 32'(m_un));
`ifdef SYNC_FIFO_FWFT_EN
      chk("rd_valid", 32'(rd_valid), 32'(n > 0));
      if (n > 0) chk("data_out_head", 32'(data_out), 32'(q[0]));
`else
      chk("rd_valid", 32'(rd_valid), 32'(m_rv));
      chk("data_out", 32'(data_out), 32'(m_do));
`endif
    end
  end

  // Called at a negedge: drives one cycle and returns at the next negedge.
  task automatic tick(input bit w, input logic [DW-1:0] d, input bit r);
    w_en = w; data_in = d; r_en = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    tick(0, 0, 0);
    tick(0, 0, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_data_out", 32'(data_out), 0);
`endif

    // Fill to full with 0x00..0x0F.
    for (int i = 0; i < DEPTH; i++) begin
      tick(1, DW'(i), 0);
      if (i == 1)  chk("aempty_at2", 32'(almost_empty), 1);
      if (i == 2)  chk("aempty_at3", 32'(almost_empty), 0);
      if (i == 12) chk("afull_at13", 32'(almost_full), 0);
      if (i == 13) chk("afull_at14", 32'(almost_full), 1);
    end
    chk("fill_count", 32'(count), 16);
    chk("fill_full", 32'(full), 1);
    tick(1, 8'hAA, 0);
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    tick(0, 0, 0);
    chk("ovf_clear", 32'(overflow), 0);

    for (int i = 0; i < DEPTH; i++) begin
      tick(0, 0, 1);
`ifndef SYNC_FIFO_FWFT_EN
      chk("drain_valid", 32'(rd_valid), 1);
      chk("drain_data", 32'(data_out), 32'(i));
`endif
    end
    tick(0, 0, 0);
    chk("drain_idle_valid", 32'(rd_valid), 0);

    // Read while empty.
    tick(0, 0, 1);
    chk("unf_pulse", 32'(underflow), 1);
    chk("unf_count", 32'(count), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("unf_data_hold", 32'(data_out), 32'h0F);
`endif
    tick(0, 0, 0);
    chk("unf_clear", 32'(underflow), 0);

    // Simultaneous at count 5.
    for (int i = 0; i < 5; i++) tick(1, DW'(8'h10 + i), 0);
    tick(1, 8'h15, 1);
    chk("both5_count", 32'(count), 5);
`ifndef SYNC_FIFO_FWFT_EN
    chk("both5_data", 32'(data_out), 32'h10);
`endif
    for (int i = 0; i < 5; i++) tick(0, 0, 1);

    // Simultaneous at full.
    for (int i = 0; i < DEPTH; i++) tick(1, DW'(8'h40 + i), 0);
    tick(1, 8'h77, 1);
    chk("bothfull_count", 32'(count), 15);
    chk("bothfull_ovf", 32'(overflow), 1);
    for (int i = 0; i < DEPTH - 1; i++) tick(0, 0, 1);

    // Simultaneous at empty.
    tick(1, 8'h99, 1);
    chk("bothempty_count", 32'(count), 1);
    chk("bothempty_unf", 32'(underflow), 1);
    tick(0, 0, 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("bothempty_readback", 32'(data_out), 32'h99);
`endif

    // Half occupancy streaming across several pointer wraps.
    for (int i = 0; i < 8; i++) tick(1, DW'($urandom), 0);
    for (int i = 0; i < 40; i++) tick(1, DW'($urandom), 1);
    chk("wrap_count", 32'(count), 8);

    // Random traffic with drifting write/read bias to reach both ends.
    for (int b = 0; b < 8; b++) begin
      automatic int wp = (b % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 50; i++)
        tick(($urandom_range(0, 99) < wp), DW'($urandom), ($urandom_range(0, 99) < 100 - wp));
    end

    // Reset mid-stream.
    for (int i = 0; i < 6; i++) tick(1, DW'($urandom), 0);
    rst_n = 1'b0;
    tick(1, 8'hEE, 1);
    rst_n = 1'b1;
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_count", 32'(count), 0);

`ifdef SYNC_FIFO_FWFT_EN
    tick(1, 8'h5A, 0);
    chk("fwft_first", 32'(data_out), 32'h5A);
    chk("fwft_valid", 32'(rd_valid), 1);
    tick(1, 8'h3C, 0);
    tick(0, 0, 1);
    chk("fwft_next", 32'(data_out), 32'h3C);
`endif

    tick(0, 0, 0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO for the DVI pipeline, such as buffering pixel or TMDS words between the line fetcher and the encoder. It is the next generation of the team's basic synchronous FIFO:
- all DEPTH entries usable (extra pointer wrap bit);
- occupancy count;
- programmable almost-full/almost-empty thresholds;
- overflow/underflow error pulses;
- read-valid strobe;
- optional first-word-fall-through read mode.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 16, number of entries; power of two, >= 2
AFULL_TH, DEPTH-2, almost_full asserted when count >= AFULL_TH; range 1..DEPTH
AEMPTY_TH, 2, almost_empty asserted when count <= AEMPTY_TH; range 0..DEPTH-1

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
w_en  in  1  write request
data_in  in  DATA_WIDTH  write data
r_en  in  1  read request (pop)
data_out  out  DATA_WIDTH  read data
rd_valid  out  1  data_out holds a newly popped word (standard mode) / head word is valid (FWFT)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_TH
almost_empty  out  1  count <= AEMPTY_TH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write rejected because full
underflow  out  1  one-cycle pulse: read rejected because empty

Behaviour:
- Reset (rst_n low at posedge clk):
  - w_ptr=0, r_ptr=0, count=0;
  - data_out=0, rd_valid=0, overflow=0, underflow=0;
  - memory contents not cleared.
  - Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=0.
  - Reset mid-operation discards all stored words; reset has priority over w_en/r_en in the same cycle.
- Pointers are ADDR_W+1 bits (ADDR_W=$clog2(DEPTH)); the low bits address memory and the MSB is the wrap bit.
- count is a register:
  - +1 on accepted write only;
  - -1 on accepted read only;
  - unchanged on both or neither.
- full, empty, almost_full, almost_empty are decoded combinationally from registered count, so they are glitch-free and update the cycle after the access.
- Accept rules are evaluated on the pre-edge state:
  - write accepted iff w_en & !full;
  - read accepted iff r_en & !empty.
- Simultaneous w_en & r_en:
  - neither full nor empty: both accepted, count unchanged;
  - full: only the read is accepted, and overflow pulses;
  - empty: only the write is accepted, and underflow pulses.
- Standard read mode (macro undefined):
  - an accepted read registers mem[r_ptr] into data_out; latency 1 cycle;
  - rd_valid=1 for exactly the following cycle;
  - data_out holds its last value otherwise.
- overflow = registered (w_en & full); underflow = registered (r_en & empty). Both are high for one cycle per rejected request and are not sticky.
- Wrap-around: pointers roll from 2*DEPTH-1 to 0 with no special handling.
- Write then read of the same entry in consecutive cycles returns the new data (no read-during-write hazard because count gates the read).

Optional Feature:
SYNC_FIFO_FWFT_EN
- Defined (first-word-fall-through):
  - data_out = mem[r_ptr] combinationally, presenting the head word with no read latency;
  - rd_valid = !empty;
  - r_en pops the head, and the next word appears in the same cycle the pop is registered;
  - a word written into an empty FIFO appears on data_out one cycle after the write;
  - the memory must use asynchronous read (distributed RAM).
- Undefined: standard registered read as above; block RAM inference is permitted.

Decomposition:
- Package sync_fifo_pkg contains:
  - function fifo_addr_w(depth) returning $clog2(depth);
  - localparam-style constants for pointer and count widths;
  - parameter-legality checks (DEPTH power of two, threshold ranges) as elaboration-time assertions.
- One sub-module, sync_fifo_mem: simple dual-port RAM with a DATA_WIDTH x DEPTH array, a write port, and a read port that is registered or asynchronous according to SYNC_FIFO_FWFT_EN.
- Pointer, count and flag logic stay in sync_fifo_flags.

Test Plan:
- Reset then idle, DEPTH=16 -> empty=1, almost_empty=1, full=0, count=0, data_out=0, rd_valid=0.
- Write 16 words 0x00..0x0F, then a 17th write of 0xAA:
  - count reaches 16, full=1, almost_full from count=14;
  - overflow pulses once, 0xAA is discarded;
  - 16 reads return 0x00..0x0F in order with rd_valid one cycle after each r_en.
- Read when empty -> underflow pulses one cycle, count stays 0, r_ptr unchanged, data_out unchanged.
- Simultaneous w_en & r_en:
  - at count=5: count stays 5 and data order is preserved;
  - at full: count goes to 15 and overflow=1;
  - at empty: count goes to 1, underflow=1, and the written word is read back next.
- Wrap test: 40 cycles of continuous write+read with pseudo-random data at ~half occupancy -> scoreboard match across three pointer wraps; assert reset mid-stream -> empty=1, count=0 the next cycle.
- With SYNC_FIFO_FWFT_EN: write 0x5A into an empty FIFO -> next cycle data_out=0x5A, rd_valid=1 without r_en; a pop of a second queued word 0x3C shows 0x3C the following cycle.
